// File: rtl/asym_pkg.sv
// Shared constants and elaboration helpers for the asymmetric-width FIFO.
// Lane order is fixed here so the RAM and any consumer agree on byte placement.
package asym_pkg;

  localparam bit LSB_FIRST = 1'b1;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    int unsigned x;
    r = 0;
    x = 1;
    while (x < v) begin
      x = x << 1;
      r++;
    end
    return r;
  endfunction

  function automatic int unsigned max(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

  function automatic int unsigned min(input int unsigned a, input int unsigned b);
    return (a < b) ? a : b;
  endfunction

  function automatic int unsigned ratio_of(input int unsigned wa, input int unsigned wb);
    return wa / max(wb, 1);
  endfunction

  // Wide side must be an exact power-of-two multiple of the narrow side.
  function automatic bit ratio_ok(input int unsigned wa, input int unsigned wb);
    int unsigned r;
    r = ratio_of(wa, wb);
    return (wa == wb * r) && (r > 1) && ((r & (r - 1)) == 0);
  endfunction

endpackage

// File: rtl/asym_downsize_fifo_if.sv
// Producer/consumer bus of the downsizing FIFO: word write side, byte read side, status.
interface asym_downsize_fifo_if #(
  parameter int unsigned WIDTHA     = 32,
  parameter int unsigned WIDTHB     = 8,
  parameter int unsigned ADDRWIDTHB = 8
);
  logic                  wr_en;
  logic [WIDTHA-1:0]     wr_data;
  logic                  full;
  logic                  rd_en;
  logic [WIDTHB-1:0]     rd_data;
  logic                  rd_valid;
  logic                  empty;
  logic [ADDRWIDTHB:0]   count;
  logic                  overflow;
  logic                  underflow;

  modport master (
    output wr_en, wr_data, rd_en,
    input  full, rd_data, rd_valid, empty, count, overflow, underflow
  );

  modport slave (
    input  wr_en, wr_data, rd_en,
    output full, rd_data, rd_valid, empty, count, overflow, underflow
  );
endinterface

// File: rtl/asym_ram_wide_wr.sv
// Block RAM stored as SIZEB narrow entries: one wide write fills RATIO consecutive entries,
// the narrow read port is registered and read-first.
module asym_ram_wide_wr
  import asym_pkg::*;
#(
  parameter int unsigned WIDTHA     = 32,
  parameter int unsigned ADDRWIDTHA = 6,
  parameter int unsigned WIDTHB     = 8,
  parameter int unsigned SIZEB      = 256,
  parameter int unsigned ADDRWIDTHB = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_wr_en,
  input  logic [ADDRWIDTHA-1:0] i_wr_addr,
  input  logic [WIDTHA-1:0]     i_wr_data,
  input  logic                  i_rd_en,
  input  logic [ADDRWIDTHB-1:0] i_rd_addr,
  output logic [WIDTHB-1:0]     o_rd_data
);
  localparam int unsigned RATIO = ratio_of(WIDTHA, WIDTHB);
  localparam int unsigned RB    = clog2(RATIO);

  logic [WIDTHB-1:0] r_mem [SIZEB];
  logic [WIDTHB-1:0] r_rd_data;

  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      for (int unsigned k = 0; k < RATIO; k++) begin
        r_mem[{i_wr_addr, RB'(LSB_FIRST ? k : RATIO - 1 - k)}] <= i_wr_data[k*WIDTHB +: WIDTHB];
      end
    end
  end

  // Output register only; the array itself is never reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_data <= '0;
    end else if (i_rd_en) begin
      r_rd_data <= r_mem[i_rd_addr];
    end
  end

  assign o_rd_data = r_rd_data;

endmodule

// File: rtl/asym_downsize_fifo.sv
// Single-clock FIFO taking WIDTHA-bit words and draining WIDTHB-bit bytes, LSB first.
// Pointers, flags and sticky error bits live here; storage is in asym_ram_wide_wr.
module asym_downsize_fifo
  import asym_pkg::*;
#(
  parameter int unsigned WIDTHA     = 32,
  parameter int unsigned SIZEA      = 64,
  parameter int unsigned ADDRWIDTHA = 6,
  parameter int unsigned WIDTHB     = 8,
  parameter int unsigned SIZEB      = 256,
  parameter int unsigned ADDRWIDTHB = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  asym_downsize_fifo_if.slave  bus
);
  localparam int unsigned RATIO = ratio_of(WIDTHA, WIDTHB);
  localparam int unsigned RB    = clog2(RATIO);
  localparam int unsigned CW    = ADDRWIDTHB + 1;

  if (!ratio_ok(WIDTHA, WIDTHB) || (SIZEB != SIZEA * RATIO) ||
      (ADDRWIDTHA != clog2(SIZEA)) || (ADDRWIDTHB != clog2(SIZEB))) begin : g_param_check
    $error("asym_downsize_fifo: inconsistent width/depth parameters");
  end

  logic [ADDRWIDTHA:0] r_wr_ptr;
  logic [ADDRWIDTHB:0] r_rd_ptr;
  logic                r_rd_valid;
  logic                r_overflow;
  logic                r_underflow;
  logic [CW-1:0]       w_count;
  logic                w_full;
  logic                w_empty;
  logic                w_wr_acc;
  logic                w_rd_acc;
  logic [WIDTHB-1:0]   w_rd_data;

  // Word pointer scaled to byte units; modulo arithmetic absorbs the wrap bits.
  assign w_count  = {r_wr_ptr, {RB{1'b0}}} - r_rd_ptr;
  assign w_empty  = (w_count == '0);
  assign w_full   = (w_count > CW'(SIZEB - RATIO));
  assign w_wr_acc = bus.wr_en && !w_full;
  assign w_rd_acc = bus.rd_en && !w_empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_rd_valid  <= 1'b0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (w_wr_acc) r_wr_ptr <= r_wr_ptr + (ADDRWIDTHA + 1)'(1);
      if (w_rd_acc) r_rd_ptr <= r_rd_ptr + CW'(1);
      r_rd_valid <= w_rd_acc;
      if (bus.wr_en && w_full)  r_overflow  <= 1'b1;
      if (bus.rd_en && w_empty) r_underflow <= 1'b1;
    end
  end

  asym_ram_wide_wr #(
    .WIDTHA     (WIDTHA),
    .ADDRWIDTHA (ADDRWIDTHA),
    .WIDTHB     (WIDTHB),
    .SIZEB      (SIZEB),
    .ADDRWIDTHB (ADDRWIDTHB)
  ) u_ram (
    .clk       (clk),
    .rst       (rst),
    .i_wr_en   (w_wr_acc),
    .i_wr_addr (r_wr_ptr[ADDRWIDTHA-1:0]),
    .i_wr_data (bus.wr_data),
    .i_rd_en   (w_rd_acc),
    .i_rd_addr (r_rd_ptr[ADDRWIDTHB-1:0]),
    .o_rd_data (w_rd_data)
  );

  assign bus.full      = w_full;
  assign bus.empty     = w_empty;
  assign bus.count     = w_count;
  assign bus.rd_data   = w_rd_data;
  assign bus.rd_valid  = r_rd_valid;
  assign bus.overflow  = r_overflow;
  assign bus.underflow = r_underflow;

endmodule

// File: tb/tb_asym_downsize_fifo.sv
// Directed bench for asym_downsize_fifo with a byte-queue reference of the expected stream.
module tb_asym_downsize_fifo;

  logic clk;
  logic rst;

  asym_downsize_fifo_if #(.WIDTHA(32), .WIDTHB(8), .ADDRWIDTHB(8)) bus ();

  asym_downsize_fifo #(
    .WIDTHA     (32),
    .SIZEA      (64),
    .ADDRWIDTHA (6),
    .WIDTHB     (8),
    .SIZEB      (256),
    .ADDRWIDTHB (8)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_errors = 0;
  int          m_count  = 0;
  logic [7:0]  exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.wr_en = 1'b0;
    bus.rd_en = 1'b0;
    bus.wr_data = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    step();
    m_count = 0;
    exp_q.delete();
  endtask

  // One clock of stimulus; checks rd_valid, rd_data and count against the byte model.
  task automatic cycle(input bit wr, input logic [31:0] d, input bit rd);
    bit         wa;
    bit         ra;
    logic [7:0] e;
    e  = '0;
    wa = wr && (m_count <= 252);
    ra = rd && (m_count != 0);
    bus.wr_en   = wr;
    bus.wr_data = d;
    bus.rd_en   = rd;
    if (ra) e = exp_q.pop_front();
    if (wa) for (int k = 0; k < 4; k++) exp_q.push_back(d[k*8 +: 8]);
    step();
    bus.wr_en = 1'b0;
    bus.rd_en = 1'b0;
    m_count = m_count + (wa ? 4 : 0) - (ra ? 1 : 0);
    check("rd_valid", {31'd0, bus.rd_valid}, {31'd0, ra});
    if (ra) check("rd_data", {24'd0, bus.rd_data}, {24'd0, e});
    check("count", {23'd0, bus.count}, m_count);
  endtask

  initial begin
    int          idx;
    int          guard;
    bit          wa_pred;
    logic [31:0] w;

    // Reset values
    do_reset();
    check("rst_count", {23'd0, bus.count}, 0);
    check("rst_empty", {31'd0, bus.empty}, 1);
    check("rst_full", {31'd0, bus.full}, 0);
    check("rst_rd_valid", {31'd0, bus.rd_valid}, 0);
    check("rst_rd_data", {24'd0, bus.rd_data}, 0);
    check("rst_overflow", {31'd0, bus.overflow}, 0);
    check("rst_underflow", {31'd0, bus.underflow}, 0);

    // Read on empty
    cycle(1'b0, 32'h0, 1'b1);
    check("uf_rd_data", {24'd0, bus.rd_data}, 0);
    check("uf_flag", {31'd0, bus.underflow}, 1);

    // Single word, four byte reads LSB first
    cycle(1'b1, 32'hDDCC_BBAA, 1'b0);
    check("w1_empty", {31'd0, bus.empty}, 0);
    cycle(1'b0, 32'h0, 1'b1);
    check("b0", {24'd0, bus.rd_data}, 32'hAA);
    cycle(1'b0, 32'h0, 1'b1);
    check("b1", {24'd0, bus.rd_data}, 32'hBB);
    cycle(1'b0, 32'h0, 1'b1);
    check("b2", {24'd0, bus.rd_data}, 32'hCC);
    cycle(1'b0, 32'h0, 1'b1);
    check("b3", {24'd0, bus.rd_data}, 32'hDD);
    check("w1_empty_end", {31'd0, bus.empty}, 1);
    step();
    check("hold_valid", {31'd0, bus.rd_valid}, 0);
    check("hold_data", {24'd0, bus.rd_data}, 32'hDD);
    check("uf_sticky", {31'd0, bus.underflow}, 1);

    // Simultaneous write and read at count 8
    do_reset();
    cycle(1'b1, 32'h4433_2211, 1'b0);
    cycle(1'b1, 32'h8877_6655, 1'b0);
    cycle(1'b1, 32'hCCBB_AA99, 1'b1);
    check("sim_count", {23'd0, bus.count}, 11);
    check("sim_byte", {24'd0, bus.rd_data}, 32'h11);
    check("sim_full", {31'd0, bus.full}, 0);
    check("sim_overflow", {31'd0, bus.overflow}, 0);
    check("sim_underflow", {31'd0, bus.underflow}, 0);
    for (int i = 0; i < 11; i++) cycle(1'b0, 32'h0, 1'b1);
    check("sim_last", {24'd0, bus.rd_data}, 32'hCC);

    // Stream 100 words with continuous reads; pointers wrap
    idx = 0;
    guard = 0;
    while (idx < 100 && guard < 2000) begin
      wa_pred = (m_count <= 252);
      w = {8'(4*idx+3), 8'(4*idx+2), 8'(4*idx+1), 8'(4*idx)};
      cycle(1'b1, w, 1'b1);
      if (wa_pred) idx++;
      guard++;
    end
    while (m_count > 0 && guard < 4000) begin
      cycle(1'b0, 32'h0, 1'b1);
      guard++;
    end
    check("stream_words", idx, 100);
    check("stream_empty", {31'd0, bus.empty}, 1);
    check("stream_last", {24'd0, bus.rd_data}, 32'h8F);

    // Fill to full, overflow, drain
    do_reset();
    for (int i = 0; i < 64; i++) cycle(1'b1, i, 1'b0);
    check("fill_full", {31'd0, bus.full}, 1);
    check("fill_count", {23'd0, bus.count}, 256);
    check("fill_overflow", {31'd0, bus.overflow}, 0);
    cycle(1'b1, 32'hDEAD_BEEF, 1'b0);
    check("of_flag", {31'd0, bus.overflow}, 1);
    check("of_count", {23'd0, bus.count}, 256);
    for (int i = 0; i < 256; i++) cycle(1'b0, 32'h0, 1'b1);
    check("drain_empty", {31'd0, bus.empty}, 1);
    check("drain_full", {31'd0, bus.full}, 0);
    check("drain_last", {24'd0, bus.rd_data}, 32'h00);

    // Asynchronous reset mid-cycle with a read in flight
    for (int i = 0; i < 25; i++) cycle(1'b1, 32'hA5A5_0000 | i, 1'b0);
    check("pre_rst_count", {23'd0, bus.count}, 100);
    bus.rd_en = 1'b1;
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("arst_count", {23'd0, bus.count}, 0);
    check("arst_empty", {31'd0, bus.empty}, 1);
    check("arst_rd_valid", {31'd0, bus.rd_valid}, 0);
    bus.rd_en = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    step();
    m_count = 0;
    exp_q.delete();
    cycle(1'b1, 32'h1122_3344, 1'b0);
    for (int i = 0; i < 4; i++) cycle(1'b0, 32'h0, 1'b1);
    check("post_rst_last", {24'd0, bus.rd_data}, 32'h11);
    check("post_rst_empty", {31'd0, bus.empty}, 1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/asym_downsize_fifo.md
Name: asym_downsize_fifo

Overview:
- Single-clock FIFO, 32-bit write side, 8-bit read side.
- Each accepted write stores one word as 4 bytes; the read side drains them one byte per read, least-significant byte first.
- Storage is an inferred block RAM: wide write port, narrow synchronous read port.
- Sits between a 32-bit producer (DMA/bus side) and a byte-serial consumer (UART/SPI-style transmitter).

Parameters:
- WIDTHA, 32, write data width.
- SIZEA, 64, depth in write words.
- ADDRWIDTHA, 6, write word address width; log2(SIZEA).
- WIDTHB, 8, read data width; WIDTHA must be WIDTHB*RATIO.
- SIZEB, 256, depth in read bytes; SIZEA*RATIO.
- ADDRWIDTHB, 8, read address width; log2(SIZEB).
- RATIO (localparam), 4, WIDTHA/WIDTHB; must be a power of two.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- wr_en  in  1  write request.
- wr_data  in  WIDTHA  write word.
- full  out  1  fewer than RATIO bytes free.
- rd_en  in  1  read request.
- rd_data  out  WIDTHB  registered read byte.
- rd_valid  out  1  rd_data holds a new byte this cycle.
- empty  out  1  no bytes stored.
- count  out  ADDRWIDTHB+1  bytes stored, 0..SIZEB.
- overflow  out  1  sticky: a write was attempted while full.
- underflow  out  1  sticky: a read was attempted while empty.

Behaviour:
- Reset (async assert, release synchronous to clk):
  - Pointers and count = 0.
  - empty=1, full=0, rd_valid=0, rd_data=0, overflow=0, underflow=0.
  - RAM array is never reset. Reset mid-operation discards all stored data; in-flight rd_valid is dropped.
- Pointers:
  - wr_ptr is ADDRWIDTHA+1 bits; rd_ptr is ADDRWIDTHB+1 bits. Each MSB is a wrap bit.
  - count = {wr_ptr, log2(RATIO) zeros} - rd_ptr, modulo 2^(ADDRWIDTHB+1).
  - count, full and empty are combinational from the registered pointers.
- Flags: empty = (count==0); full = (count > SIZEB-RATIO).
- Write (wr_en && !full):
  - Byte k of wr_data (bits 8k+7:8k) goes to byte address {wr_ptr[ADDRWIDTHA-1:0], k}.
  - wr_ptr increments, wrapping at SIZEA.
- Write while full: ignored. RAM and pointers unchanged. overflow<=1.
- Read (rd_en && !empty):
  - RAM[rd_ptr[ADDRWIDTHB-1:0]] is registered into rd_data.
  - rd_valid=1 on the next cycle; read latency is exactly 1 cycle.
  - rd_ptr increments, wrapping at SIZEB.
- Read while empty: ignored. rd_valid=0 next cycle, rd_data holds, underflow<=1.
- rd_valid is 0 in any cycle not preceded by an accepted read. rd_data holds its last value when no read is accepted.
- Simultaneous accepted write and read: both take effect; count changes by +RATIO-1.
- full and empty are sampled before the current cycle's updates:
  - A write into an empty FIFO does not allow a same-cycle read; empty deasserts the cycle after the write.
  - A read from a full FIFO does not allow a same-cycle write.
- The RAM read port is read-first with respect to the write port. A same-address collision cannot occur because of the flag rules.
- overflow and underflow clear only on rst.
- Throughput: one byte per cycle sustained on the read side; one word per cycle on the write side until full.

Decomposition:
- Shared package asym_pkg holds:
  - clog2, max and min constant functions.
  - RATIO derivation and the WIDTHA == WIDTHB*RATIO check.
  - Byte-lane ordering constant LSB_FIRST=1.
- One sub-module, asym_ram_wide_wr:
  - Single clock; WIDTHA write port with word address; WIDTHB registered read port with byte address.
  - Memory declared as SIZEB x WIDTHB; the write port writes RATIO consecutive entries.
  - Pointer, flag and sticky logic stay in the top level.

Test Plan:
- Reset, write 0xDDCCBBAA, then assert rd_en 4 cycles -> rd_data AA,BB,CC,DD, each with rd_valid=1 one cycle after rd_en; count goes 4,3,2,1,0; empty=1 after the last read.
- Write 64 words 0x00000000..0x0000003F -> full=1 at count=256. A 65th write is dropped and overflow=1. Draining all 256 bytes returns the original data unchanged.
- rd_en on empty after reset -> rd_valid=0, rd_data=0, underflow=1. A subsequent valid write/read still works, and underflow stays 1.
- With count=8, assert wr_en and rd_en in the same cycle -> count=11 next cycle, one byte output, no flag set.
- Stream 100 words through while reading continuously (pointers wrap 1+ times) -> output is the exact byte sequence, LSB-first, with no gaps once count>0.
- With count=100 and rd_en active, assert rst asynchronously mid-cycle -> count=0, empty=1, rd_valid=0 immediately. A post-release write/read returns the new data only.
